// File: rtl/link_watchdog_pkg.sv
// Shared constants for the link watchdog and the reset generator it feeds.
// Both blocks derive their timing from the single clock-rate constant below.
package link_watchdog_pkg;

  // FSM state encoding (also exported on the debug state port)
  localparam int WD_STATE_W = 3;
  localparam logic [WD_STATE_W-1:0] WD_IDLE    = 3'd0;
  localparam logic [WD_STATE_W-1:0] WD_ARMED   = 3'd1;
  localparam logic [WD_STATE_W-1:0] WD_TRIG    = 3'd2;
  localparam logic [WD_STATE_W-1:0] WD_HOLDOFF = 3'd3;
  localparam logic [WD_STATE_W-1:0] WD_FAULT   = 3'd4;

  // System clock rate; timeout is half a second, holdoff 11 seconds
  localparam longint unsigned WD_CLK_HZ = 64'd100_000_000;
  localparam logic [31:0] WD_TIMEOUT_DEF   = 32'(WD_CLK_HZ / 64'd2);
  localparam logic [31:0] WD_HOLDOFF_DEF   = 32'(WD_CLK_HZ * 64'd11);
  localparam logic [3:0]  WD_MAX_RETRY_DEF = 4'd3;

  // Saturating increment used for the retry counter
  function automatic logic [3:0] wd_sat_inc(input logic [3:0] value, input logic [3:0] limit);
    return (value >= limit) ? limit : value + 4'd1;
  endfunction

endpackage

// File: rtl/link_watchdog_wd_timer.sv
// Shared watchdog timer: synchronous clear, count enable, and a terminal-count
// flag against a limit chosen at run time by the FSM (timeout or holdoff).
// The counter reloads to zero on its own terminal count, so it never wraps.
module wd_timer
  import link_watchdog_pkg::*;
#(
  parameter int unsigned CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             en,
  input  logic [CNT_W-1:0] limit,
  output logic             tc
);

  logic [CNT_W-1:0] count_reg;
  logic [CNT_W-1:0] count_next;

  // Terminal count is the last cycle of a limit-long interval
  assign tc = (count_reg == (limit - CNT_W'(1)));

  // Next-count selection: clear wins, then count with self-reload at terminal
  always_comb begin
    count_next = count_reg;
    if (clr) begin
      count_next = '0;
    end else if (en) begin
      count_next = tc ? '0 : count_reg + CNT_W'(1);
    end
  end

  // Counter register with asynchronous reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_reg <= '0;
    end else begin
      count_reg <= count_next;
    end
  end

endmodule

// File: rtl/link_watchdog.sv
// Activity watchdog feeding the system reset generator. Watches a data-path
// strobe; after TIMEOUT silent clocks it emits a one-cycle rst_trig, then
// ignores the link for HOLDOFF clocks while the reset completes. After
// MAX_RETRY unrecovered triggers it latches fault until fault_clr.
module link_watchdog
  import link_watchdog_pkg::*;
#(
  parameter int unsigned      CNT_W     = 32,
  parameter logic [CNT_W-1:0] TIMEOUT   = CNT_W'(WD_TIMEOUT_DEF),
  parameter logic [CNT_W-1:0] HOLDOFF   = CNT_W'(WD_HOLDOFF_DEF),
  parameter logic [3:0]       MAX_RETRY = WD_MAX_RETRY_DEF
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  enable,
  input  logic                  activity,
  input  logic                  manual_trig,
  input  logic                  fault_clr,
  output logic                  rst_trig,
  output logic                  fault,
  output logic [3:0]            retry_cnt,
  output logic [WD_STATE_W-1:0] state
);

  logic [WD_STATE_W-1:0] state_reg;
  logic [WD_STATE_W-1:0] state_next;
  logic [3:0]            retry_reg;
  logic [3:0]            retry_next;
  logic                  rst_trig_reg;
  logic                  fault_reg;

  logic                  timer_clr;
  logic                  timer_en;
  logic                  timer_tc;
  logic [CNT_W-1:0]      timer_limit;

  // The one timer measures silence in ARMED and the reset wait in HOLDOFF
  assign timer_limit = (state_reg == WD_HOLDOFF) ? HOLDOFF : TIMEOUT;

  wd_timer #(
    .CNT_W (CNT_W)
  ) u_timer (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (timer_clr),
    .en    (timer_en),
    .limit (timer_limit),
    .tc    (timer_tc)
  );

  // Next-state, retry and timer-control decode; timer is cleared on every
  // state change so each interval starts from zero
  always_comb begin
    state_next = state_reg;
    retry_next = retry_reg;
    timer_clr  = 1'b1;
    timer_en   = 1'b0;
    case (state_reg)
      WD_IDLE: begin
        // Stay disarmed until the stream has been seen alive once
        if (enable && manual_trig) begin
          state_next = WD_TRIG;
        end else if (enable && activity) begin
          state_next = WD_ARMED;
          retry_next = '0;
        end
      end
      WD_ARMED: begin
        timer_clr = 1'b0;
        timer_en  = 1'b1;
        if (!enable) begin
          state_next = WD_IDLE;
          timer_clr  = 1'b1;
        end else if (manual_trig) begin
          // Software request is not a retry, even on the timeout edge
          state_next = WD_TRIG;
          timer_clr  = 1'b1;
        end else if (activity) begin
          // Link alive: restart the silence window and forgive retries
          retry_next = '0;
          timer_clr  = 1'b1;
        end else if (timer_tc) begin
          timer_clr = 1'b1;
          if (retry_reg >= MAX_RETRY) begin
            state_next = WD_FAULT;
          end else begin
            state_next = WD_TRIG;
            retry_next = wd_sat_inc(retry_reg, MAX_RETRY);
          end
        end
      end
      WD_TRIG: begin
        state_next = WD_HOLDOFF;
      end
      WD_HOLDOFF: begin
        // Link is deliberately ignored while the downstream reset runs
        timer_clr = 1'b0;
        timer_en  = 1'b1;
        if (!enable) begin
          state_next = WD_IDLE;
          timer_clr  = 1'b1;
        end else if (timer_tc) begin
          state_next = WD_ARMED;
          timer_clr  = 1'b1;
        end
      end
      WD_FAULT: begin
        if (fault_clr) begin
          state_next = WD_IDLE;
          retry_next = '0;
        end
      end
      default: begin
        state_next = WD_IDLE;
        retry_next = '0;
      end
    endcase
  end

  // State, retry count and registered outputs; outputs track the next state
  // so rst_trig is high exactly during the TRIG cycle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg    <= WD_IDLE;
      retry_reg    <= '0;
      rst_trig_reg <= 1'b0;
      fault_reg    <= 1'b0;
    end else begin
      state_reg    <= state_next;
      retry_reg    <= retry_next;
      rst_trig_reg <= (state_next == WD_TRIG);
      fault_reg    <= (state_next == WD_FAULT);
    end
  end

  assign rst_trig  = rst_trig_reg;
  assign fault     = fault_reg;
  assign retry_cnt = retry_reg;
  assign state     = state_reg;

endmodule

// File: tb/tb_link_watchdog.sv
// Directed bench for link_watchdog with TIMEOUT=8, HOLDOFF=20, MAX_RETRY=2.
module tb_link_watchdog;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       enable;
  logic       activity;
  logic       manual_trig;
  logic       fault_clr;
  logic       rst_trig;
  logic       fault;
  logic [3:0] retry_cnt;
  logic [2:0] state;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  link_watchdog #(
    .CNT_W     (32),
    .TIMEOUT   (32'd8),
    .HOLDOFF   (32'd20),
    .MAX_RETRY (4'd2)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .enable      (enable),
    .activity    (activity),
    .manual_trig (manual_trig),
    .fault_clr   (fault_clr),
    .rst_trig    (rst_trig),
    .fault       (fault),
    .retry_cnt   (retry_cnt),
    .state       (state)
  );

  // Advance one rising edge, then settle just after it
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Tick until rst_trig is seen (bounded); n = ticks taken, or -1
  task automatic wait_pulse(input int max_ticks, output int n);
    n = -1;
    for (int i = 1; i <= max_ticks && n < 0; i++) begin
      tick();
      if (rst_trig === 1'b1) n = i;
    end
  endtask

  // Tick n times counting rst_trig pulses
  task automatic run_count(input int n, output int pulses);
    pulses = 0;
    for (int i = 0; i < n; i++) begin
      tick();
      if (rst_trig === 1'b1) pulses++;
    end
  endtask

  task automatic release_reset();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; enable = 1'b0; activity = 1'b0; manual_trig = 1'b0; fault_clr = 1'b0;
    #23;
    checks++; if (state !== 3'd0) begin errors++; $display("FAIL reset_state got %0d want 0", state); end
    checks++; if (rst_trig !== 1'b0) begin errors++; $display("FAIL reset_rst_trig got %0b want 0", rst_trig); end
    checks++; if (fault !== 1'b0) begin errors++; $display("FAIL reset_fault got %0b want 0", fault); end
    checks++; if (retry_cnt !== 4'd0) begin errors++; $display("FAIL reset_retry got %0d want 0", retry_cnt); end
    release_reset();
    enable = 1'b1;
    tick();
    $display("test_reset: done");
  endtask

  task automatic test_no_activity();
    int pulses;
    run_count(100, pulses);
    checks++; if (pulses !== 0) begin errors++; $display("FAIL idle_pulses got %0d want 0", pulses); end
    checks++; if (state !== 3'd0) begin errors++; $display("FAIL idle_state got %0d want 0", state); end
    $display("test_no_activity: pulses=%0d", pulses);
  endtask

  task automatic test_timeout_retry();
    int n;
    int pulses;
    activity = 1'b1; tick(); activity = 1'b0;
    checks++; if (state !== 3'd1) begin errors++; $display("FAIL arm_state got %0d want 1", state); end
    wait_pulse(20, n);
    checks++; if (n !== 8) begin errors++; $display("FAIL first_pulse_delay got %0d want 8", n); end
    checks++; if (retry_cnt !== 4'd1) begin errors++; $display("FAIL first_retry got %0d want 1", retry_cnt); end
    checks++; if (state !== 3'd2) begin errors++; $display("FAIL first_trig_state got %0d want 2", state); end
    wait_pulse(40, n);
    checks++; if (n !== 29) begin errors++; $display("FAIL second_pulse_spacing got %0d want 29", n); end
    checks++; if (retry_cnt !== 4'd2) begin errors++; $display("FAIL second_retry got %0d want 2", retry_cnt); end
    run_count(28, pulses);
    checks++; if (pulses !== 0) begin errors++; $display("FAIL pre_fault_pulses got %0d want 0", pulses); end
    checks++; if (state !== 3'd1) begin errors++; $display("FAIL pre_fault_state got %0d want 1", state); end
    tick();
    checks++; if (state !== 3'd4) begin errors++; $display("FAIL fault_state got %0d want 4", state); end
    checks++; if (fault !== 1'b1) begin errors++; $display("FAIL fault_level got %0b want 1", fault); end
    checks++; if (rst_trig !== 1'b0) begin errors++; $display("FAIL fault_no_pulse got %0b want 0", rst_trig); end
    enable = 1'b0; tick(); enable = 1'b1; activity = 1'b1; tick(); activity = 1'b0; tick();
    checks++; if (state !== 3'd4) begin errors++; $display("FAIL fault_sticky got %0d want 4", state); end
    fault_clr = 1'b1; tick(); fault_clr = 1'b0;
    checks++; if (state !== 3'd0) begin errors++; $display("FAIL clr_state got %0d want 0", state); end
    checks++; if (fault !== 1'b0) begin errors++; $display("FAIL clr_fault got %0b want 0", fault); end
    checks++; if (retry_cnt !== 4'd0) begin errors++; $display("FAIL clr_retry got %0d want 0", retry_cnt); end
    $display("test_timeout_retry: done");
  endtask

  task automatic test_periodic();
    int pulses = 0;
    for (int i = 0; i < 200; i++) begin
      activity = ((i % 7) == 0);
      tick();
      if (rst_trig === 1'b1) pulses++;
    end
    activity = 1'b0;
    checks++; if (pulses !== 0) begin errors++; $display("FAIL period7_pulses got %0d want 0", pulses); end
    checks++; if (state !== 3'd1) begin errors++; $display("FAIL period7_state got %0d want 1", state); end
    $display("test_periodic: pulses=%0d", pulses);
  endtask

  task automatic test_period9_holdoff();
    int n;
    int pulses;
    activity = 1'b1; tick(); activity = 1'b0;
    wait_pulse(20, n);
    checks++; if (n !== 8) begin errors++; $display("FAIL period9_delay got %0d want 8", n); end
    checks++; if (retry_cnt !== 4'd1) begin errors++; $display("FAIL period9_retry got %0d want 1", retry_cnt); end
    tick();
    checks++; if (state !== 3'd3) begin errors++; $display("FAIL holdoff_state got %0d want 3", state); end
    checks++; if (rst_trig !== 1'b0) begin errors++; $display("FAIL pulse_width got %0b want 0", rst_trig); end
    manual_trig = 1'b1; activity = 1'b1; tick(); manual_trig = 1'b0; activity = 1'b0;
    checks++; if (rst_trig !== 1'b0) begin errors++; $display("FAIL holdoff_manual got %0b want 0", rst_trig); end
    run_count(18, pulses);
    checks++; if (pulses !== 0) begin errors++; $display("FAIL holdoff_pulses got %0d want 0", pulses); end
    checks++; if (state !== 3'd3) begin errors++; $display("FAIL holdoff_end_state got %0d want 3", state); end
    tick();
    checks++; if (state !== 3'd1) begin errors++; $display("FAIL rearm_state got %0d want 1", state); end
    run_count(7, pulses);
    activity = 1'b1; tick(); activity = 1'b0;
    checks++; if (pulses !== 0 || rst_trig !== 1'b0) begin errors++; $display("FAIL coincident_pulse got %0d/%0b want 0/0", pulses, rst_trig); end
    checks++; if (state !== 3'd1) begin errors++; $display("FAIL coincident_state got %0d want 1", state); end
    checks++; if (retry_cnt !== 4'd0) begin errors++; $display("FAIL coincident_retry got %0d want 0", retry_cnt); end
    $display("test_period9_holdoff: done");
  endtask

  task automatic test_manual();
    int n;
    int pulses;
    wait_pulse(20, n);
    checks++; if (n !== 8) begin errors++; $display("FAIL manual_pre_delay got %0d want 8", n); end
    run_count(21, pulses);
    checks++; if (state !== 3'd1) begin errors++; $display("FAIL manual_pre_state got %0d want 1", state); end
    manual_trig = 1'b1; tick(); manual_trig = 1'b0;
    checks++; if (rst_trig !== 1'b1) begin errors++; $display("FAIL manual_pulse got %0b want 1", rst_trig); end
    checks++; if (retry_cnt !== 4'd1) begin errors++; $display("FAIL manual_retry got %0d want 1", retry_cnt); end
    tick();
    run_count(20, pulses);
    checks++; if (state !== 3'd1) begin errors++; $display("FAIL manual_rearm got %0d want 1", state); end
    run_count(7, pulses);
    manual_trig = 1'b1; tick(); manual_trig = 1'b0;
    checks++; if (rst_trig !== 1'b1 || state !== 3'd2) begin errors++; $display("FAIL manual_tc_pulse got %0b/%0d want 1/2", rst_trig, state); end
    checks++; if (retry_cnt !== 4'd1) begin errors++; $display("FAIL manual_tc_retry got %0d want 1", retry_cnt); end
    $display("test_manual: done");
  endtask

  task automatic test_async_reset();
    int n;
    int pulses;
    // Still in the TRIG cycle from the previous test
    #2 rst_n = 1'b0; #1;
    checks++; if (rst_trig !== 1'b0 || state !== 3'd0) begin errors++; $display("FAIL rst_trig_abort got %0b/%0d want 0/0", rst_trig, state); end
    checks++; if (retry_cnt !== 4'd0) begin errors++; $display("FAIL rst_trig_retry got %0d want 0", retry_cnt); end
    release_reset();
    activity = 1'b1; tick(); activity = 1'b0;
    manual_trig = 1'b1; tick(); manual_trig = 1'b0;
    run_count(4, pulses);
    checks++; if (state !== 3'd3) begin errors++; $display("FAIL rst_hold_pre got %0d want 3", state); end
    #2 rst_n = 1'b0; #1;
    checks++; if (state !== 3'd0 || rst_trig !== 1'b0 || fault !== 1'b0) begin errors++; $display("FAIL rst_hold got %0d/%0b/%0b want 0/0/0", state, rst_trig, fault); end
    release_reset();
    activity = 1'b1; tick(); activity = 1'b0;
    wait_pulse(20, n);
    wait_pulse(40, n);
    run_count(29, pulses);
    checks++; if (fault !== 1'b1) begin errors++; $display("FAIL rst_fault_pre got %0b want 1", fault); end
    #2 rst_n = 1'b0; #1;
    checks++; if (fault !== 1'b0 || state !== 3'd0 || retry_cnt !== 4'd0) begin errors++; $display("FAIL rst_fault got %0b/%0d/%0d want 0/0/0", fault, state, retry_cnt); end
    release_reset();
    $display("test_async_reset: done");
  endtask

  task automatic test_enable_drop();
    int pulses;
    activity = 1'b1; tick(); activity = 1'b0;
    run_count(3, pulses);
    enable = 1'b0; tick();
    checks++; if (state !== 3'd0) begin errors++; $display("FAIL disable_state got %0d want 0", state); end
    activity = 1'b1; tick(); activity = 1'b0;
    run_count(20, pulses);
    checks++; if (state !== 3'd0 || pulses !== 0) begin errors++; $display("FAIL disabled_idle got %0d/%0d want 0/0", state, pulses); end
    enable = 1'b1;
    $display("test_enable_drop: pulses=%0d", pulses);
  endtask

  initial begin
    test_reset();
    test_no_activity();
    test_timeout_retry();
    test_periodic();
    test_period9_holdoff();
    test_manual();
    test_async_reset();
    test_enable_drop();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/link_watchdog.md
# link_watchdog

Activity watchdog that sits directly upstream of the system reset generator and drives its `rst_trig` input. It monitors a data-path activity strobe, such as the ADC/demodulator frame-valid. If the strobe goes silent for `TIMEOUT` clocks, it issues a single-cycle reset request. It then waits `HOLDOFF` clocks while the downstream reset completes before re-arming. Consecutive unrecovered retries are bounded by `MAX_RETRY`; once exhausted, the block latches a fault instead of requesting further resets.

## Interface
- `CNT_W`, default 32: width of the shared timer.
- `TIMEOUT`, default 32'd50_000_000: silence length, in clocks, that causes a trigger. Must be ≥2.
- `HOLDOFF`, default 32'd1_100_000_000: clocks spent ignoring activity after a trigger. Must exceed the downstream reset sequence length. Must be ≥2.
- `MAX_RETRY`, default 4'd3: timeout triggers allowed without intervening activity. Range 1..15.

Ports:
- `clk`  in  1  system clock
- `rst_n`  in  1  reset, asynchronous, active-low
- `enable`  in  1  watchdog enable, level
- `activity`  in  1  one-clock strobe from the data path; level-high counts every cycle
- `manual_trig`  in  1  software reset request, one-clock strobe
- `fault_clr`  in  1  clears FAULT, one-clock strobe
- `rst_trig`  out  1  reset request to the reset generator, exactly one clock wide, registered
- `fault`  out  1  retry limit exhausted, level
- `retry_cnt`  out  4  timeout triggers since the last observed activity
- `state`  out  3  current FSM state, for debug

## Operation
- FSM states: IDLE=0, ARMED=1, TRIG=2, HOLDOFF=3, FAULT=4. There is one shared timer.
- **IDLE**: timer held at 0.
  - `enable && activity` → ARMED.
  - `enable && manual_trig` → TRIG.
  - Timeouts never fire before the stream has been seen alive once.
- **ARMED**:
  - `activity` clears the timer to 0 and clears `retry_cnt` to 0.
  - Otherwise the timer increments each clock.
  - Timer == TIMEOUT-1 with no activity: if `retry_cnt == MAX_RETRY` → FAULT (no pulse); else → TRIG and `retry_cnt` +1.
  - `manual_trig` → TRIG; `retry_cnt` unchanged.
  - `!enable` → IDLE.
- **TRIG**: lasts one clock with `rst_trig`=1, then → HOLDOFF with the timer at 0.
- **HOLDOFF**: timer counts to HOLDOFF-1, then → ARMED with the timer at 0. `activity` and `manual_trig` are ignored. `!enable` → IDLE.
- **FAULT**:
  - `fault`=1; `rst_trig` is never asserted.
  - `fault_clr` → IDLE and `retry_cnt`=0.
  - `enable` is ignored.
- Edge priorities:
  - ARMED: `!enable` > `manual_trig` > `activity` > timeout. Activity on the timeout edge therefore suppresses the trigger.
  - Manual and timeout on the same edge produce one uncounted TRIG.
- Width rules: timer is `CNT_W` bits and never wraps, because terminal compare resets it. `retry_cnt` saturates at `MAX_RETRY`.

## Timing
- Reset values: `state`=IDLE, timer=0, `rst_trig`=0, `fault`=0, `retry_cnt`=0.
- Async reset mid-operation forces the reset values immediately. A `rst_trig` pulse in flight is truncated, and `fault` is cleared.
- Activity last sampled at edge k and silence afterwards: `rst_trig` is high for the single cycle following edge k+TIMEOUT.
- `manual_trig` sampled at edge e: `rst_trig` is high for the cycle following edge e.
- Minimum spacing between consecutive timeout pulses is 1+HOLDOFF+TIMEOUT clocks.
- `fault` rises one clock after the terminal-count edge and falls one clock after `fault_clr` is sampled.

## Structure
- Shared package holds:
  - state encoding constants `WD_IDLE`…`WD_FAULT` and the 3-bit state width;
  - default `TIMEOUT`/`HOLDOFF` constants, so the reset generator and watchdog derive from one clock-rate constant.
- One natural sub-module: `wd_timer`, a `CNT_W`-bit counter with sync clear, enable, and a terminal-count flag against a runtime-selected limit (TIMEOUT or HOLDOFF).
- The FSM and retry counter stay in the top level.

## Test plan
Common settings: TIMEOUT=8, HOLDOFF=20, MAX_RETRY=2, enable=1.
- No activity for 100 clocks after reset → `rst_trig` stays 0 and `state`=IDLE.
- Single activity at edge 10, then silence → `rst_trig` pulses after edge 18 and `retry_cnt`=1. Second pulse after edge 47, 29 clocks later; `retry_cnt`=2.
- Continued silence → at edge 76 `state`=FAULT, `fault`=1, no third pulse. `fault_clr` → IDLE, `retry_cnt`=0, `fault`=0.
- Activity every 7 clocks for 200 clocks → no pulse. Period 9 → pulse 8 clocks after each strobe. Activity coincident with the terminal edge → no pulse.
- `manual_trig` in ARMED → pulse next cycle, `retry_cnt` unchanged. `manual_trig` during HOLDOFF → ignored.
- `rst_n` low during HOLDOFF, and low during TRIG → all outputs 0 and `state`=IDLE asynchronously. `enable` dropped in ARMED → IDLE, no pulse.
